// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory request-side master.
package mem_pkg;

  localparam int MEM_WIDTH_DEF      = 8;
  localparam int MEM_ADDR_WIDTH_DEF = 4;
  localparam int MEM_DEPTH_DEF      = 4;
  localparam int MEM_TIMEOUT_DEF    = 16;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} mem_q_state_e;

  typedef struct packed {
    logic                          wr_rd;
    logic [MEM_ADDR_WIDTH_DEF-1:0] addr;
    logic [MEM_WIDTH_DEF-1:0]      wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_cmd_fifo.sv
// Synchronous command FIFO; exposes the head and the entry behind it so the
// issuer can reload back-to-back in the same cycle it pops.
module mem_cmd_fifo
  import mem_pkg::*;
#(
  parameter type cmd_t = mem_cmd_t,
  parameter int  DEPTH = MEM_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  push,
  input  logic                  pop,
  input  cmd_t                  din,
  output cmd_t                  head,
  output cmd_t                  next,
  output logic [$clog2(DEPTH):0] count,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_nxt;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_nxt  = rd_ptr + 1'b1;
  assign head    = mem[rd_ptr];
  assign next    = mem[rd_nxt];

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage is data only; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_req_queue.sv
// Buffers client commands and issues them one at a time on the memory
// valid/ready port, returning read data as a single-cycle response pulse.
module mem_req_queue
  import mem_pkg::*;
#(
  parameter int WIDTH      = MEM_WIDTH_DEF,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH_DEF,
  parameter int DEPTH      = MEM_DEPTH_DEF,
  parameter int TIMEOUT    = MEM_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr_rd,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  err,
  output logic                  valid,
  input  logic                  ready,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      rdata
);

  typedef struct packed {
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
  } q_cmd_t;

  localparam int CW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  mem_q_state_e    state, state_n;
  q_cmd_t          cmd_q, cmd_n, head, next, req_cmd;
  logic            valid_n;
  logic [TW-1:0]   wait_cnt, wait_n;
  logic            rsp_valid_n, err_n;
  logic [WIDTH-1:0]      rsp_data_n;
  logic [ADDR_WIDTH-1:0] rsp_addr_n;
  logic            push, fifo_pop, full, empty;
  logic [CW:0]     count;

  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign req_cmd   = '{wr_rd: req_wr_rd, addr: req_addr, wdata: req_wdata};

  mem_cmd_fifo #(
    .cmd_t (q_cmd_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (push),
    .pop   (fifo_pop),
    .din   (req_cmd),
    .head  (head),
    .next  (next),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n     = state;
    valid_n     = valid;
    cmd_n       = cmd_q;
    wait_n      = wait_cnt;
    fifo_pop    = 1'b0;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data;
    rsp_addr_n  = rsp_addr;
    err_n       = err;
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        if (!empty) begin
          cmd_n   = head;
          valid_n = 1'b1;
          wait_n  = '0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (ready) begin
          fifo_pop = 1'b1;
          if (!cmd_q.wr_rd) begin
            rsp_valid_n = 1'b1;
            rsp_data_n  = rdata;
            rsp_addr_n  = cmd_q.addr;
          end
          // Reload from the entry behind the head so issue stays gapless.
          if (count > (CW+1)'(1)) begin
            cmd_n  = next;
            wait_n = '0;
          end else begin
            valid_n = 1'b0;
            state_n = IDLE;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          fifo_pop = 1'b1;
          err_n    = 1'b1;
          valid_n  = 1'b0;
          state_n  = IDLE;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      valid     <= 1'b0;
      cmd_q     <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      valid     <= valid_n;
      cmd_q     <= cmd_n;
      wait_cnt  <= wait_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
      rsp_addr  <= rsp_addr_n;
      err       <= err_n;
    end
  end

  assign wr_rd = cmd_q.wr_rd;
  assign addr  = cmd_q.addr;
  assign wdata = cmd_q.wdata;

endmodule

// File: tb/tb_mem_req_queue.sv
// Bench for mem_req_queue: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_req_queue;

  localparam int W = 8, AW = 4, DEPTH = 4, TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          res, req_valid, req_ready, req_wr_rd;
  logic [AW-1:0] req_addr, rsp_addr, addr;
  logic [W-1:0]  req_wdata, rsp_data, wdata, rdata;
  logic          rsp_valid, err, valid, ready, wr_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_req_queue #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .res(res), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr_rd(req_wr_rd), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr), .err(err),
    .valid(valid), .ready(ready), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
    .rdata(rdata)
  );

  // Memory slave
  logic [W-1:0] mem_arr [16];
  assign rdata = mem_arr[addr];
  always @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= W'(8'h40 + i);
    end else if (valid && ready && wr_rd) begin
      mem_arr[addr] <= wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending commands plus the one on the bus
  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } cmd_s;

  cmd_s          q[$];
  cmd_s          m_out;
  logic          m_valid = 1'b0;
  int            m_wait = 0;
  logic          m_rsp_valid = 1'b0;
  logic [W-1:0]  m_rsp_data = '0;
  logic [AW-1:0] m_rsp_addr = '0;
  logic          m_err = 1'b0;
  logic [W-1:0]  mm [16];
  logic          mdl_on = 1'b0;

  always @(posedge clk) begin : mdl
    int   sz;
    logic pushed;
    cmd_s nc, tmp;
    if (res) begin
      q.delete();
      m_valid = 1'b0; m_wait = 0; m_rsp_valid = 1'b0;
      m_rsp_data = '0; m_rsp_addr = '0; m_err = 1'b0;
      for (int i = 0; i < 16; i++) mm[i] = W'(8'h40 + i);
      mdl_on = 1'b1;
    end else begin
      sz     = q.size();
      pushed = req_valid && (sz != DEPTH);
      nc     = '{req_wr_rd, req_addr, req_wdata};
      m_rsp_valid = 1'b0;
      if (m_valid) begin
        if (ready) begin
          tmp = q.pop_front();
          if (m_out.wr) mm[m_out.a] = m_out.d;
          else begin
            m_rsp_valid = 1'b1;
            m_rsp_data  = mm[m_out.a];
            m_rsp_addr  = m_out.a;
          end
          if (sz > 1) begin m_out = q[0]; m_wait = 0; end
          else m_valid = 1'b0;
        end else if (m_wait == TIMEOUT - 1) begin
          tmp = q.pop_front();
          m_err = 1'b1;
          m_valid = 1'b0;
        end else begin
          m_wait++;
        end
      end else if (sz != 0) begin
        m_out = q[0]; m_valid = 1'b1; m_wait = 0;
      end
      if (pushed) q.push_back(nc);
    end
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("req_ready", req_ready, (q.size() != DEPTH));
      chk("valid", valid, m_valid);
      if (m_valid) begin
        chk("wr_rd", wr_rd, m_out.wr);
        chk("addr", addr, m_out.a);
        chk("wdata", wdata, m_out.d);
      end
      chk("rsp_valid", rsp_valid, m_rsp_valid);
      if (m_rsp_valid) begin
        chk("rsp_data", rsp_data, m_rsp_data);
        chk("rsp_addr", rsp_addr, m_rsp_addr);
      end
      chk("err", err, m_err);
    end
  end

  // Activity counters for directed scenarios
  int            n_valid = 0, n_rsp = 0, n_hs = 0;
  logic [W-1:0]  last_rsp_data = '0;
  logic [AW-1:0] last_rsp_addr = '0;
  logic [AW-1:0] hs_addr[$];
  always @(negedge clk) begin
    if (valid) n_valid++;
    if (rsp_valid) begin
      n_rsp++;
      last_rsp_data = rsp_data;
      last_rsp_addr = rsp_addr;
    end
    if (valid && ready) begin
      n_hs++;
      hs_addr.push_back(addr);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
    req_valid = 1'b1; req_wr_rd = w; req_addr = a; req_wdata = d;
    cyc(1);
    req_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog sim_time actual=%0t required=finish", $time);
    $fatal(1);
  end

  initial begin
    int b_v, b_r, b_h, run;
    res = 1'b1; ready = 1'b0; req_valid = 1'b0;
    req_wr_rd = 1'b0; req_addr = '0; req_wdata = '0;

    // Reset values
    cyc(2);
    chk("rst_valid", valid, 0);
    chk("rst_wr_rd", wr_rd, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_req_ready", req_ready, 1);
    res = 1'b0;
    cyc(3);
    chk("idle_valid", valid, 0);

    // Write then read back
    ready = 1'b1;
    b_v = n_valid; b_r = n_rsp;
    push(1'b1, 4'd3, 8'hA5);
    push(1'b0, 4'd3, 8'h00);
    cyc(5);
    chk("wr_rd_valid_cycles", n_valid - b_v, 2);
    chk("wr_rd_rsp_pulses", n_rsp - b_r, 1);
    chk("wr_rd_rsp_data", last_rsp_data, 8'hA5);
    chk("wr_rd_rsp_addr", last_rsp_addr, 3);

    // Fill FIFO with memory stalled
    ready = 1'b0;
    b_h = n_hs;
    push(1'b1, 4'd1, 8'h11);
    push(1'b1, 4'd2, 8'h22);
    push(1'b1, 4'd3, 8'h33);
    push(1'b1, 4'd4, 8'h44);
    chk("full_req_ready", req_ready, 0);
    push(1'b1, 4'd5, 8'h55);
    chk("full_req_ready_after5", req_ready, 0);
    ready = 1'b1;
    cyc(6);
    chk("full_hs_count", n_hs - b_h, 4);
    for (int i = 0; i < 4; i++) chk("full_order", hs_addr[b_h + i], i + 1);
    chk("full_drained_req_ready", req_ready, 1);
    ready = 1'b0;

    // Backpressure hold
    b_h = n_hs;
    push(1'b1, 4'd7, 8'h3C);
    cyc(1);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) ready = 1'b1;
      @(negedge clk);
      chk("bp_valid", valid, 1);
      chk("bp_addr", addr, 7);
      chk("bp_wdata", wdata, 8'h3C);
      chk("bp_wr_rd", wr_rd, 1);
      @(posedge clk); #2;
    end
    ready = 1'b0;
    cyc(2);
    chk("bp_hs_count", n_hs - b_h, 1);
    chk("bp_valid_after", valid, 0);

    // Timeout drops a stalled read, next command then issues
    chk("to_err_before", err, 0);
    push(1'b0, 4'd9, 8'h00);
    push(1'b1, 4'd10, 8'h55);
    run = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!valid) break;
      run++;
    end
    chk("to_valid_run", run, 16);
    chk("to_err", err, 1);
    @(posedge clk); #2;
    chk("to_next_valid", valid, 1);
    chk("to_next_addr", addr, 10);
    ready = 1'b1;
    cyc(3);
    chk("to_err_sticky", err, 1);
    chk("to_idle", valid, 0);

    // Reset in the middle of a read burst
    push(1'b0, 4'd3, 8'h00);
    push(1'b0, 4'd4, 8'h00);
    push(1'b0, 4'd5, 8'h00);
    res = 1'b1;
    cyc(1);
    res = 1'b0;
    b_r = n_rsp; b_h = n_hs;
    cyc(5);
    chk("mid_rst_rsp", n_rsp - b_r, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_err", err, 0);
    push(1'b1, 4'd6, 8'h77);
    cyc(3);
    chk("post_rst_hs", n_hs - b_h, 1);
    chk("post_rst_mem", mem_arr[6], 8'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
